// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive-frame capture FIFO with FWFT read port and status
module uart_rx_fifo #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_dout,
  input  logic                  rx_error,
  input  logic                  rx_busy,
  output logic [7:0]            rd_data,
  output logic                  rd_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  flush,
  input  logic                  clr_status,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  overflow,
  output logic [7:0]            err_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [8:0]            mem_q [DEPTH];

  logic push, pop, accept, drop, err_inc;

  // A completed frame is the falling edge of the receiver's busy flag.
  assign push = busy_q & ~rx_busy;
  assign pop  = rd_valid & rd_ready & ~flush;

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign accept  = push & ~flush & (~full | pop);
  assign drop    = push & ~flush & full & ~pop;
  assign err_inc = accept & rx_error;

  // Next-state for pointers, occupancy and status.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    err_count_d = err_count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (pop && !accept) count_d = count_q - 1'b1;
    end

    // A fresh event in the clear cycle takes precedence over the clear.
    if (clr_status) begin
      overflow_d  = drop;
      err_count_d = err_inc ? 8'd1 : 8'd0;
    end else begin
      if (drop) overflow_d = 1'b1;
      if (err_inc && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      busy_q      <= rx_busy;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      err_count_q <= err_count_d;
    end
  end

  // Entry storage; contents need no reset because rd_valid gates the read side.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {rx_error, rx_dout};
  end

  assign rd_valid  = (count_q != '0);
  assign full      = (count_q == DEPTH_CNT);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign err_count = err_count_q;
  // Head is forced to zero while empty so stale memory never shows.
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q][7:0] : 8'd0;
  assign rd_err    = rd_valid ? mem_q[rd_ptr_q][8]   : 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_dout = 8'd0;
  logic       rx_error = 1'b0;
  logic       rx_busy = 1'b0;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       flush = 1'b0;
  logic       clr_status = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of {err,data}, sticky flag, saturating counter.
  logic [8:0] mq[$];
  bit         m_ovf;
  int         m_err;

  uart_rx_fifo #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rx_dout(rx_dout), .rx_error(rx_error), .rx_busy(rx_busy),
    .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .flush(flush), .clr_status(clr_status), .count(count), .full(full),
    .overflow(overflow), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [8:0] head;
    head = (mq.size() != 0) ? mq[0] : 9'd0;
    chk("count", 32'(count), 32'(mq.size()));
    chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    chk("full", 32'(full), 32'(mq.size() == 16));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("rd_data", 32'(rd_data), 32'(head[7:0]));
    chk("rd_err", 32'(rd_err), 32'(head[8]));
  endtask

  // Drive one cycle of inputs, apply the model's rules for that cycle, then check.
  task automatic drive(input logic busy, input logic [7:0] d, input logic e, input logic rdy,
                       input logic fl, input logic clr, input bit fe);
    bit do_pop, ovf_ev, acc;
    rx_busy = busy; rx_dout = d; rx_error = e; rd_ready = rdy; flush = fl; clr_status = clr;
    do_pop = rdy && (mq.size() != 0);
    acc = 1'b0; ovf_ev = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      ovf_ev = fe && (mq.size() == 16) && !do_pop;
      acc    = fe && !ovf_ev;
      if (do_pop) void'(mq.pop_front());
      if (acc) mq.push_back({e, d});
    end
    if (clr) begin
      m_ovf = ovf_ev;
      m_err = (acc && e) ? 1 : 0;
    end else begin
      if (ovf_ev) m_ovf = 1'b1;
      if (acc && e && m_err < 255) m_err++;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input logic rdy, input logic fl, input logic clr);
    drive(1'b0, 8'($urandom), 1'($urandom), rdy, fl, clr, 1'b0);
  endtask

  // A frame: busy high for 1..3 cycles (data scrambled meanwhile), then the falling edge.
  task automatic frame(input logic [7:0] d, input logic e, input logic rdy,
                       input logic fl, input logic clr, input logic brdy);
    int n;
    n = $urandom_range(1, 3);
    repeat (n) drive(1'b1, 8'($urandom), 1'($urandom), brdy, 1'b0, 1'b0, 1'b0);
    drive(1'b0, d, e, rdy, fl, clr, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_busy = 1'b0; rd_ready = 1'b0; flush = 1'b0; clr_status = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_ovf = 1'b0; m_err = 0;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: three frames then drain in order
    do_reset();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(rd_valid), 32'd0);
    frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_first_head", 32'(rd_data), 32'hA5);
    frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_count3", 32'(count), 32'd3);
    chk("t1_head_a5", 32'(rd_data), 32'hA5);
    idle(1'b1, 1'b0, 1'b0);
    chk("t1_pop2_head", 32'(rd_data), 32'h3C);
    idle(1'b1, 1'b0, 1'b0);
    chk("t1_pop3_head", 32'(rd_data), 32'hFF);
    idle(1'b1, 1'b0, 1'b0);
    chk("t1_empty", 32'(rd_valid), 32'd0);
    idle(1'b1, 1'b0, 1'b0);

    // Test 2: idle through reset, plus a frame cut by reset
    rx_busy = 1'b0;
    do_reset();
    repeat (20) idle(1'b0, 1'b0, 1'b0);
    chk("t2_idle_count", 32'(count), 32'd0);
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(1'b0, 1'b0, 1'b0);
    chk("t2_midframe_lost", 32'(count), 32'd0);

    // Test 3: fill, overflow, drain
    for (int i = 0; i < 16; i++) frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_count16", 32'(count), 32'd16);
    chk("t3_head0", 32'(rd_data), 32'h00);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_data", 32'(rd_data), 32'(i));
      idle(1'b1, 1'b0, 1'b0);
    end
    chk("t3_drained", 32'(rd_valid), 32'd0);

    // Test 4: push and pop together while full
    do_reset();
    for (int i = 0; i < 16; i++) frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_count16", 32'(count), 32'd16);
    chk("t4_no_overflow", 32'(overflow), 32'd0);
    repeat (15) idle(1'b1, 1'b0, 1'b0);
    chk("t4_last_entry", 32'(rd_data), 32'h99);
    idle(1'b1, 1'b0, 1'b0);

    // Test 5: errored frames, clear, saturation
    do_reset();
    frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_err2", 32'(err_count), 32'd2);
    chk("t5_rd_err_a", 32'(rd_err), 32'd1);
    idle(1'b1, 1'b0, 1'b0);
    chk("t5_rd_err_b", 32'(rd_err), 32'd1);
    chk("t5_data_b", 32'(rd_data), 32'h22);
    idle(1'b1, 1'b0, 1'b1);
    chk("t5_clr_err", 32'(err_count), 32'd0);
    chk("t5_clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 260; i++) frame(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_saturate", 32'(err_count), 32'd255);
    frame(8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_clr_vs_err", 32'(err_count), 32'd1);
    repeat (2) idle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_clr_vs_ovf", 32'(overflow), 32'd1);

    // Test 6: flush during a frame end, overflow preserved, pointers restart
    do_reset();
    for (int i = 0; i < 17; i++) frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (11) idle(1'b1, 1'b0, 1'b0);
    chk("t6_count5", 32'(count), 32'd5);
    frame(8'h88, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_valid", 32'(rd_valid), 32'd0);
    chk("t6_flush_ovf", 32'(overflow), 32'd1);
    frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_after_count", 32'(count), 32'd1);
    chk("t6_after_data", 32'(rd_data), 32'h77);

    // Randomized mix: slow draining first, then fast draining
    for (int i = 0; i < 400; i++) begin
      logic rdy;
      rdy = (i < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        frame(8'($urandom), 1'($urandom), rdy, ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 15) == 0), 1'($urandom));
      else
        idle(rdy, ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
